// File: rtl/cpu_bus_arbiter.sv
// rtl/cpu_bus_arbiter.sv - two-master round-robin bus arbiter with registered bus outputs and watchdog
module cpu_bus_arbiter #(
  parameter int unsigned TIMEOUT  = 1023,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_request,
  input  logic [31:0] m0_address,
  input  logic        m0_write,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_request,
  input  logic [31:0] m1_address,
  input  logic        m1_write,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic        mem_request,
  output logic [31:0] mem_address,
  output logic        mem_write,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        timeout_err
);

  localparam int CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_q, state_d;
  logic            grant_q, last_grant_q;
  logic [CW-1:0]   cnt_q;
  logic            any_req, choice, ack_done, timeout_hit, finish;

  // Only one requester wins outright; on a tie the master not served last time wins.
  assign any_req     = m0_request | m1_request;
  assign choice      = (m0_request & m1_request) ? ~last_grant_q : m1_request;
  assign ack_done    = (state_q == BUSY) & mem_ack;
  assign timeout_hit = (TIMEOUT != 0) && (state_q == BUSY) && !mem_ack && (cnt_q == TO_LAST);
  assign finish      = ack_done | timeout_hit;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = BUSY;
      BUSY:    if (finish)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_request = (state_q == BUSY);
    m0_ack      = finish & ~grant_q;
    m1_ack      = finish & grant_q;
    timeout_err = timeout_hit;
    m0_rdata    = (timeout_hit & ~grant_q) ? ERR_DATA : mem_rdata;
    m1_rdata    = (timeout_hit & grant_q)  ? ERR_DATA : mem_rdata;
  end

  // Transaction fields are captured once at grant and held for the whole BUSY phase.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      mem_address  <= '0;
      mem_write    <= 1'b0;
      mem_wstrb    <= '0;
      mem_wdata    <= '0;
    end else if (state_q == IDLE && any_req) begin
      grant_q      <= choice;
      last_grant_q <= choice;
      mem_address  <= choice ? m1_address : m0_address;
      mem_write    <= choice ? m1_write   : m0_write;
      mem_wstrb    <= choice ? m1_wstrb   : m0_wstrb;
      mem_wdata    <= choice ? m1_wdata   : m0_wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (state_q == IDLE) begin
      cnt_q <= '0;
    end else if (!mem_ack && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// tb/tb_cpu_bus_arbiter.sv - randomized self-checking bench for cpu_bus_arbiter
module tb_cpu_bus_arbiter;

  localparam int TO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [31:0] addr [2];
  logic        wr [2];
  logic [3:0]  wstrb [2];
  logic [31:0] wdata [2];
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ack, m1_ack;
  logic        mem_request, mem_write, timeout_err;
  logic [31:0] mem_address, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  int checks = 0;
  int passes = 0;
  int last_model = 1;

  always #5 clock = ~clock;

  cpu_bus_arbiter #(.TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clock(clock), .reset(reset),
    .m0_request(req[0]), .m0_address(addr[0]), .m0_write(wr[0]), .m0_wstrb(wstrb[0]),
    .m0_wdata(wdata[0]), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_request(req[1]), .m1_address(addr[1]), .m1_write(wr[1]), .m1_wstrb(wstrb[1]),
    .m1_wdata(wdata[1]), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_request(mem_request), .mem_address(mem_address), .mem_write(mem_write),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .timeout_err(timeout_err)
  );

  task automatic set_master(input int m, input logic [31:0] a, input logic w,
                            input logic [3:0] s, input logic [31:0] d);
    addr[m] = a; wr[m] = w; wstrb[m] = s; wdata[m] = d; req[m] = 1'b1;
  endtask

  // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the cycle after completion.
  // ack_cyc: BUSY cycle (1-based) carrying mem_ack; 0 or >TO means the bus never answers.
  task automatic run_txn(input int ack_cyc, input logic [31:0] rd, input string tag);
    int w;
    bit done, to;
    logic [69:0] got, exp;
    logic [1:0] ack_got, ack_exp;
    logic [31:0] rd_w, rd_o, rd_exp;
    if (req == 2'b11) w = 1 - last_model;
    else if (req[1]) w = 1;
    else w = 0;
    last_model = w;
    @(negedge clock);
    checks++;
    if (mem_request !== 1'b0 || {m1_ack, m0_ack} !== 2'b00)
      $display("FAIL %s.idle: mem_request=%b acks=%b expected 0/00", tag, mem_request, {m1_ack, m0_ack});
    else passes++;
    @(posedge clock); #1;
    done = 0;
    for (int k = 1; k <= TO && !done; k++) begin
      mem_ack   = (k == ack_cyc);
      mem_rdata = (k == ack_cyc) ? rd : $urandom;
      @(negedge clock);
      got = {mem_request, mem_address, mem_write, mem_wstrb, mem_wdata};
      exp = {1'b1, addr[w], wr[w], wstrb[w], wdata[w]};
      checks++;
      if (got !== exp) $display("FAIL %s.bus[%0d]: got %h expected %h", tag, k, got, exp);
      else passes++;
      to   = (k == TO) && (k != ack_cyc);
      done = (k == ack_cyc) || (k == TO);
      ack_got = {m1_ack, m0_ack};
      ack_exp = done ? (w == 1 ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if (ack_got !== ack_exp || timeout_err !== to)
        $display("FAIL %s.ack[%0d]: acks=%b terr=%b expected %b/%b", tag, k, ack_got, timeout_err, ack_exp, to);
      else passes++;
      if (done) begin
        rd_w   = (w == 1) ? m1_rdata : m0_rdata;
        rd_o   = (w == 1) ? m0_rdata : m1_rdata;
        rd_exp = to ? ERR : rd;
        checks++;
        if (rd_w !== rd_exp || rd_o !== mem_rdata)
          $display("FAIL %s.rdata: got %h/%h expected %h/%h", tag, rd_w, rd_o, rd_exp, mem_rdata);
        else passes++;
      end
      @(posedge clock); #1;
    end
    mem_ack = 1'b0;
    req[w]  = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1 mem_ack = 1'b1;
    @(negedge clock);
    checks++;
    if ({mem_request, mem_address, mem_write, mem_wstrb, mem_wdata, m0_ack, m1_ack, timeout_err} !== '0)
      $display("FAIL reset: bus=%b %h %b %h %h acks=%b%b terr=%b expected all 0", mem_request, mem_address,
               mem_write, mem_wstrb, mem_wdata, m1_ack, m0_ack, timeout_err);
    else passes++;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    reset = 1'b1;
    last_model = 1;
  endtask

  task automatic test_tie();
    set_master(0, 32'h0000_0200, 1'b0, 4'hF, 32'h0);
    set_master(1, 32'h0000_0300, 1'b1, 4'hF, 32'h1111_2222);
    for (int i = 0; i < 4; i++) begin
      run_txn(2, 32'hA000_0000 + i, "tie");
      if (i < 3) req = 2'b11;
    end
    req = 2'b00;
  endtask

  task automatic test_single_read();
    set_master(0, 32'h0000_0100, 1'b0, 4'hF, 32'h0);
    run_txn(3, 32'h1234_5678, "single_read");
  endtask

  task automatic test_write();
    set_master(1, 32'h8000_0010, 1'b1, 4'b0011, 32'h0000_AABB);
    run_txn(4, 32'h0, "write");
  endtask

  task automatic test_timeout();
    set_master(0, 32'h0000_0400, 1'b0, 4'hF, 32'h0);
    run_txn(0, 32'h0, "timeout");
    mem_ack = 1'b1;
    @(negedge clock);
    checks++;
    if ({m1_ack, m0_ack, mem_request, timeout_err} !== 4'b0000)
      $display("FAIL late_ack: acks=%b mem_request=%b terr=%b expected 0", {m1_ack, m0_ack}, mem_request, timeout_err);
    else passes++;
    @(posedge clock); #1;
    mem_ack = 1'b0;
  endtask

  task automatic test_ack_on_timeout();
    set_master(1, 32'h0000_0500, 1'b0, 4'hF, 32'h0);
    run_txn(TO, 32'h5555_AAAA, "ack_on_timeout");
  endtask

  task automatic test_reset_mid_busy();
    set_master(0, 32'h0000_0600, 1'b0, 4'hF, 32'h0);
    @(posedge clock); #1;
    @(negedge clock);
    checks++;
    if (mem_request !== 1'b1) $display("FAIL mid_busy.grant: mem_request=%b expected 1", mem_request);
    else passes++;
    reset = 1'b0;
    req = 2'b00;
    #1;
    checks++;
    if (mem_request !== 1'b0 || mem_address !== 32'h0)
      $display("FAIL mid_busy.async: mem_request=%b addr=%h expected 0/0", mem_request, mem_address);
    else passes++;
    @(posedge clock); #1;
    reset = 1'b1;
    last_model = 1;
    mem_ack = 1'b1;
    @(negedge clock);
    checks++;
    if ({m1_ack, m0_ack, mem_request} !== 3'b000)
      $display("FAIL mid_busy.stray: acks=%b mem_request=%b expected 0", {m1_ack, m0_ack}, mem_request);
    else passes++;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    set_master(0, 32'h0000_0700, 1'b0, 4'hF, 32'h0);
    set_master(1, 32'h0000_0800, 1'b0, 4'hF, 32'h0);
    run_txn(1, 32'hCAFE_0001, "mid_busy_tie");
    req = 2'b00;
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      for (int m = 0; m < 2; m++)
        if (!req[m] && $urandom_range(0, 1) == 1)
          set_master(m, $urandom, 1'($urandom), 4'($urandom), $urandom);
      if (req == 2'b00) begin
        int m = $urandom_range(0, 1);
        set_master(m, $urandom, 1'($urandom), 4'($urandom), $urandom);
      end
      mem_ack = ($urandom_range(0, 3) == 0);
      run_txn($urandom_range(1, TO + 2), $urandom, "random");
    end
    req = 2'b00;
    @(posedge clock); #1;
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      addr[m] = '0; wr[m] = 1'b0; wstrb[m] = '0; wdata[m] = '0;
    end
    test_reset();
    test_tie();
    test_single_read();
    test_write();
    test_timeout();
    test_ack_on_timeout();
    test_reset_mid_busy();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
